ddk_ch_arbiter: RTL

- Shares the eight 6-bit CH banks (CH1..CH8) between NREQ protocol engines inside the core.
- Each engine requests one bank by index. The arbiter grants banks round-robin per bank and routes the owner's OUT/OE to the bank and the bank's IN to the owner.
- Every ownership change goes through a break-before-make turnaround with the bank tri-stated, so pads are never driven by two engines back to back.
- Sits between the protocol engines and the BIBUF pad drivers.

---
 rtl/ddk_ch_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ddk_ch_arbiter.sv
// Shares eight 6-bit CH pin banks between NREQ protocol engines.
// Each bank arbitrates round-robin and inserts a tri-stated turnaround on every acquire and release.
module ddk_ch_arbiter #(
  parameter int NREQ        = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                SysClk,
  input  logic                SysRst,
  input  logic [NREQ-1:0]     REQ,
  input  logic [3*NREQ-1:0]   REQ_BANK,
  input  logic [6*NREQ-1:0]   REQ_OUT,
  input  logic [6*NREQ-1:0]   REQ_OE,
  output logic [NREQ-1:0]     GNT,
  output logic [6*NREQ-1:0]   REQ_IN,
  output logic [47:0]         CH_OUT,
  output logic [47:0]         CH_OE,
  input  logic [47:0]         CH_IN,
  output logic [7:0]          BANK_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_OWNED = 2'd2,
    ST_REL   = 2'd3
  } bank_st_e;

  localparam logic [3:0] CNT_INIT = 4'(TURN_CYCLES - 1);
  localparam logic [2:0] PTR_INIT = 3'(NREQ - 1);

  bank_st_e        state_q [8];
  bank_st_e        state_d [8];
  logic [2:0]      owner_q [8];
  logic [2:0]      owner_d [8];
  logic [2:0]      ptr_q   [8];
  logic [2:0]      ptr_d   [8];
  logic [3:0]      cnt_q   [8];
  logic [3:0]      cnt_d   [8];
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] gnt_d;
  logic [NREQ-1:0] engaged_s;

  // Requesters already waiting on or holding some bank are not candidates anywhere.
  always_comb begin
    engaged_s = '0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((state_q[b] == ST_ACQ || state_q[b] == ST_OWNED) && owner_q[b] == 3'(i)) begin
          engaged_s[i] = 1'b1;
        end
      end
    end
  end

  // Per-bank next state: round-robin pick in IDLE, turnaround counting in ACQ/REL.
  always_comb begin
    int   idx;
    logic found;
    logic owner_req;
    for (int b = 0; b < 8; b++) begin
      state_d[b] = state_q[b];
      owner_d[b] = owner_q[b];
      ptr_d[b]   = ptr_q[b];
      cnt_d[b]   = cnt_q[b];
      found      = 1'b0;
      idx        = 0;
      owner_req  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q[b] == 3'(i)) begin
          owner_req = REQ[i];
        end
      end
      case (state_q[b])
        ST_IDLE: begin
          for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q[b]) + k) % NREQ;
            if (!found && REQ[idx] && REQ_BANK[3*idx +: 3] == 3'(b) && !engaged_s[idx]) begin
              found      = 1'b1;
              owner_d[b] = 3'(idx);
              ptr_d[b]   = 3'(idx);
              cnt_d[b]   = CNT_INIT;
              state_d[b] = ST_ACQ;
            end
          end
        end
        ST_ACQ: begin
          if (!owner_req) begin
            owner_d[b] = 3'd0;
            cnt_d[b]   = CNT_INIT;
            state_d[b] = ST_REL;
          end else if (cnt_q[b] == 4'd0) begin
            state_d[b] = ST_OWNED;
          end else begin
            cnt_d[b] = cnt_q[b] - 4'd1;
          end
        end
        ST_OWNED: begin
          if (!owner_req) begin
            cnt_d[b]   = CNT_INIT;
            state_d[b] = ST_REL;
          end else begin
            state_d[b] = ST_OWNED;
          end
        end
        ST_REL: begin
          if (cnt_q[b] == 4'd0) begin
            state_d[b] = ST_IDLE;
          end else begin
            cnt_d[b] = cnt_q[b] - 4'd1;
          end
        end
        default: begin
          state_d[b] = ST_IDLE;
        end
      endcase
    end
  end

  // Grant follows the next OWNED state so it rises on the ACQ->OWNED edge itself.
  always_comb begin
    gnt_d = '0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (state_d[b] == ST_OWNED && owner_d[b] == 3'(i)) begin
          gnt_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge SysClk or negedge SysRst) begin
    if (!SysRst) begin
      for (int b = 0; b < 8; b++) begin
        state_q[b] <= ST_IDLE;
        owner_q[b] <= 3'd0;
        ptr_q[b]   <= PTR_INIT;
        cnt_q[b]   <= 4'd0;
      end
      gnt_q <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        state_q[b] <= state_d[b];
        owner_q[b] <= owner_d[b];
        ptr_q[b]   <= ptr_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      gnt_q <= gnt_d;
    end
  end

  // Pin routing: banks are driven only while OWNED, so pads see no same-cycle handover.
  always_comb begin
    CH_OUT    = '0;
    CH_OE     = '0;
    REQ_IN    = '0;
    BANK_BUSY = '0;
    for (int b = 0; b < 8; b++) begin
      BANK_BUSY[b] = (state_q[b] != ST_IDLE);
      for (int i = 0; i < NREQ; i++) begin
        if (state_q[b] == ST_OWNED && owner_q[b] == 3'(i)) begin
          CH_OUT[6*b +: 6] = REQ_OUT[6*i +: 6];
          CH_OE[6*b +: 6]  = REQ_OE[6*i +: 6];
          REQ_IN[6*i +: 6] = CH_IN[6*b +: 6];
        end
      end
    end
  end

  assign GNT = gnt_q;

endmodule
